// File: rtl/booth_product_accumulator.sv
// Saturating signed accumulator for a programmed number of 64-bit Booth products.
// Products arrive on a valid/ready handshake; the registered sum is returned on a second one.
module booth_product_accumulator #(
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_busy,
  input  logic             i_prod_valid,
  output logic             o_prod_ready,
  input  logic [63:0]      i_prod,
  output logic             o_acc_valid,
  input  logic             i_acc_ready,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_overflow
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [ACC_W-1:0]   acc_q, acc_nxt;
  logic [CNT_W-1:0]   rem_q, rem_nxt;
  logic               ovf_q, ovf_nxt;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [SUM_W-1:0] sum_wide;
  logic [ACC_W-1:0]        sum_sat;
  logic                    sum_ovf;

  // One guard bit: the sum overflowed when the top two bits disagree.
  assign prod_ext = ACC_W'($signed(i_prod));
  assign sum_wide = SUM_W'($signed(acc_q)) + SUM_W'(prod_ext);
  assign sum_ovf  = sum_wide[SUM_W-1] ^ sum_wide[SUM_W-2];
  assign sum_sat  = !sum_ovf ? sum_wide[ACC_W-1:0]
                  : (sum_wide[SUM_W-1] ? ACC_MIN : ACC_MAX);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      acc_q   <= acc_nxt;
      rem_q   <= rem_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_q;
    rem_nxt   = rem_q;
    ovf_nxt   = ovf_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (i_len != '0) begin
            rem_nxt   = i_len;
            state_nxt = ACCUM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ACCUM: begin
        if (i_prod_valid) begin
          acc_nxt = sum_sat;
          ovf_nxt = ovf_q | sum_ovf;
          rem_nxt = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_acc_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags decode straight from the state register.
  assign o_busy       = (state_q == ACCUM) || (state_q == DONE);
  assign o_prod_ready = (state_q == ACCUM);
  assign o_acc_valid  = (state_q == DONE);
  assign o_acc        = acc_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator (ACC_W=64 so saturation is reachable).
module tb_booth_product_accumulator;

  localparam int unsigned ACC_W = 64;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             busy;
  logic             prod_valid = 1'b0;
  logic             prod_ready;
  logic [63:0]      prod = '0;
  logic             acc_valid;
  logic             acc_ready = 1'b0;
  logic [ACC_W-1:0] acc;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  booth_product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .o_busy(busy),
    .i_prod_valid(prod_valid), .o_prod_ready(prod_ready), .i_prod(prod),
    .o_acc_valid(acc_valid), .i_acc_ready(acc_ready), .o_acc(acc),
    .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [CNT_W-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [63:0] p);
    prod_valid = 1'b1;
    prod       = p;
    tick();
    prod_valid = 1'b0;
  endtask

  logic [7:0] gap_pat [7] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1};

  initial begin
    // Reset state
    #2;
    check_eq("rst_acc", acc, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'(prod_ready), 64'd0);
    check_eq("rst_valid", 64'(acc_valid), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic sum, back-to-back products
    start_job(8'd3);
    check_eq("basic_ready", 64'(prod_ready), 64'd1);
    check_eq("basic_busy", 64'(busy), 64'd1);
    prod_valid = 1'b1;
    prod = 64'd5;                   tick();
    prod = 64'hFFFF_FFFF_FFFF_FFFE; tick();
    check_eq("basic_valid_early", 64'(acc_valid), 64'd0);
    prod = 64'h0000_0001_0000_0000; tick();
    prod_valid = 1'b0;
    check_eq("basic_valid", 64'(acc_valid), 64'd1);
    check_eq("basic_acc", acc, 64'h0000_0001_0000_0003);
    check_eq("basic_ovf", 64'(overflow), 64'd0);
    check_eq("basic_ready_done", 64'(prod_ready), 64'd0);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check_eq("basic_idle_valid", 64'(acc_valid), 64'd0);
    check_eq("basic_idle_busy", 64'(busy), 64'd0);
    check_eq("basic_idle_hold", acc, 64'h0000_0001_0000_0003);
    tick();

    // Gaps on the product stream and result backpressure
    start_job(8'd4);
    prod = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 7; i++) begin
      prod_valid = gap_pat[i][0];
      tick();
    end
    prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("gap_valid", 64'(acc_valid), 64'd1);
      check_eq("gap_acc", acc, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
    end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check_eq("gap_idle", 64'(busy), 64'd0);
    tick();

    // Zero-length job goes straight to DONE
    prod = 64'd9;
    prod_valid = 1'b1;
    start_job(8'd0);
    check_eq("zero_valid", 64'(acc_valid), 64'd1);
    check_eq("zero_ready", 64'(prod_ready), 64'd0);
    check_eq("zero_acc", acc, 64'd0);
    prod_valid = 1'b0;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    tick();

    // Positive saturation
    start_job(8'd2);
    push(64'h7FFF_FFFF_FFFF_FFFF);
    check_eq("satp_mid_ovf", 64'(overflow), 64'd0);
    push(64'd1);
    check_eq("satp_acc", acc, 64'h7FFF_FFFF_FFFF_FFFF);
    check_eq("satp_ovf", 64'(overflow), 64'd1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    tick();

    // Negative saturation, overflow flag cleared by the new job first
    start_job(8'd2);
    check_eq("satn_ovf_clr", 64'(overflow), 64'd0);
    push(64'h8000_0000_0000_0000);
    push(64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("satn_acc", acc, 64'h8000_0000_0000_0000);
    check_eq("satn_ovf", 64'(overflow), 64'd1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    tick();

    // Asynchronous reset in the middle of a job
    start_job(8'd5);
    push(64'd10);
    push(64'd20);
    check_eq("mid_acc_pre", acc, 64'd30);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_acc", acc, 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_ready", 64'(prod_ready), 64'd0);
    #1;
    rst = 1'b1;
    tick();
    check_eq("mid_rst_idle", 64'(busy), 64'd0);
    start_job(8'd1);
    push(64'd7);
    check_eq("mid_next_valid", 64'(acc_valid), 64'd1);
    check_eq("mid_next_acc", acc, 64'd7);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    tick();

    // i_start held high through ACCUM and DONE
    start = 1'b1;
    len   = 8'd2;
    tick();
    len = 8'd9;
    push(64'd100);
    check_eq("ign_ready", 64'(prod_ready), 64'd1);
    push(64'd200);
    check_eq("ign_valid", 64'(acc_valid), 64'd1);
    check_eq("ign_acc", acc, 64'd300);
    tick();
    check_eq("ign_hold", acc, 64'd300);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check_eq("ign_idle", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    check_eq("ign_restart", 64'(prod_ready), 64'd1);
    check_eq("ign_restart_acc", acc, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
- Downstream consumer of the 64-bit signed products from the radix-4 Booth multiplier stage.
- Accepts a programmed number of products over a valid/ready handshake and sums them into a wide signed accumulator.
- Saturates on signed overflow and presents the registered sum over an output valid/ready handshake.
- Serves as the accumulate half of a dot-product / MAC path built around the multiplier.

Parameters:
ACC_W, 72, accumulator and result width in bits; legal range 64..128.
CNT_W, 8, width of the product-count field; a job covers 1..2^CNT_W-1 products.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  reset; asynchronous, active-low.
i_start  input  1  job start request; sampled only in IDLE.
i_len  input  CNT_W  number of products in the job; sampled with i_start.
o_busy  output  1  high in ACCUM and DONE.
i_prod_valid  input  1  product available from the multiplier stage.
o_prod_ready  output  1  accumulator accepts a product this cycle.
i_prod  input  64  signed two's-complement product.
o_acc_valid  output  1  result available.
i_acc_ready  input  1  downstream accepts the result.
o_acc  output  ACC_W  signed accumulated result.
o_overflow  output  1  job saturated at least once; valid alongside o_acc.

Behaviour:
- Reset (i_rst low, asynchronous), all outputs and state cleared:
  - FSM goes to IDLE; accumulator and remaining-count are 0.
  - o_acc = 0, o_acc_valid = 0, o_prod_ready = 0, o_busy = 0, o_overflow = 0.
  - Reset mid-job discards the partial sum; no result is emitted.
- FSM states: IDLE, ACCUM, DONE. All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- IDLE:
  - o_prod_ready = 0; o_acc holds the previous job's result.
  - i_start=1 with i_len!=0: latch i_len into the remaining-count, clear the accumulator and overflow flag, go to ACCUM.
  - i_start=1 with i_len==0: clear the accumulator and overflow flag, go directly to DONE (result 0).
- ACCUM:
  - o_prod_ready = 1.
  - On a handshake (i_prod_valid & o_prod_ready): acc <= sat(acc + sign_extend(i_prod, ACC_W)), remaining <= remaining - 1.
  - If remaining == 1 at the handshake, go to DONE next cycle. o_acc_valid rises the cycle after the final product handshake.
  - No handshake: state is held; gaps in i_prod_valid of any length are legal.
  - i_start is ignored.
- DONE:
  - o_acc_valid = 1; o_acc and o_overflow are stable until the handshake.
  - i_acc_ready=1: go to IDLE next cycle; o_acc_valid drops.
  - i_start is ignored, including in the handshake cycle; a new job needs i_start in IDLE. Minimum 1 idle cycle between jobs.
- Arithmetic:
  - Signed add at ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that value; if below -2^(ACC_W-1), clamp to that value. Either case sets o_overflow, which is sticky for the job.
  - With ACC_W >= 64+CNT_W, overflow is unreachable, but the logic is still present.
- A handshake on i_prod is only possible in ACCUM; products presented in IDLE or DONE are not consumed and must be held by upstream.

Test Plan:
- Basic sum: reset, i_start with i_len=3, products 5, -2, 0x0000_0001_0000_0000 back-to-back -> o_acc_valid exactly 1 cycle after the 3rd handshake; o_acc = 0x1_0000_0003; o_overflow = 0.
- Backpressure/gaps: i_len=4, i_prod_valid toggled 1-0-0-1-1-0-1 with products all -1, i_acc_ready held low 5 cycles -> o_acc = -4, held stable with o_acc_valid high for all 5 cycles; IDLE the cycle after i_acc_ready.
- Zero length: i_start with i_len=0 -> DONE next cycle, o_acc = 0, o_prod_ready never asserted.
- Saturation (ACC_W=64): i_len=2, products 0x7FFF_FFFF_FFFF_FFFF and 1 -> o_acc = 0x7FFF_FFFF_FFFF_FFFF, o_overflow = 1. Repeat with 0x8000_0000_0000_0000 and -1 -> o_acc = 0x8000_0000_0000_0000, o_overflow = 1.
- Reset mid-job: i_len=5, 2 products accepted, i_rst pulsed low between clock edges -> outputs 0 immediately without a clock; next job with i_len=1, product 7 gives o_acc = 7.
- Ignored start: i_start held high throughout ACCUM and DONE of an i_len=2 job -> no restart, result correct; the new job begins only from IDLE.
